// File: rtl/display_scan_controller.sv
// Time-multiplexed 7-segment digit scanner: blanking gap before each digit,
// masked-digit skipping and an end-of-frame pulse.
module display_scan_controller #(
    parameter int unsigned PRESCALE   = 1000,
    parameter int unsigned BLANK      = 4,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] digit_mask,
    output logic [2:0] sel,
    output logic [7:0] anode,
    output logic       blank,
    output logic       frame_done
);

    localparam int unsigned CNT_MAX = (PRESCALE > BLANK) ? PRESCALE : BLANK;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK - 1);
    localparam logic [CW-1:0] SHOW_LOAD  = CW'(PRESCALE - 1);
    localparam logic [7:0]    DIGIT_BITS = 8'((1 << NUM_DIGITS) - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    sel_nxt;
    logic [7:0]    anode_nxt;
    logic          blank_nxt;
    logic          frame_done_nxt;
    logic [7:0]    eff_mask;
    logic [3:0]    hit_low, hit_here, hit_next;

    // Returns {found, index} of the first set bit at or after start, wrapping
    // modulo NUM_DIGITS; scanning offsets high-to-low leaves the nearest hit.
    function automatic logic [3:0] find_from(input logic [7:0] m, input int unsigned start);
        logic [3:0] r;
        logic [2:0] idx;
        r = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            idx = 3'((start + (NUM_DIGITS - 1 - i)) % NUM_DIGITS);
            if (m[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    assign eff_mask = digit_mask & DIGIT_BITS;
    assign hit_low  = find_from(eff_mask, 0);
    assign hit_here = find_from(eff_mask, int'(sel));
    assign hit_next = find_from(eff_mask, int'(sel) + 1);

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        sel_nxt        = sel;
        anode_nxt      = anode;
        blank_nxt      = blank;
        frame_done_nxt = 1'b0;
        if (!enable) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            sel_nxt   = '0;
            anode_nxt = '0;
            blank_nxt = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_BLANK;
                    sel_nxt   = hit_low[3] ? hit_low[2:0] : '0;
                    cnt_nxt   = BLANK_LOAD;
                    anode_nxt = '0;
                    blank_nxt = 1'b1;
                end
                S_BLANK: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CW'(1);
                    end else if (eff_mask[sel]) begin
                        state_nxt = S_SHOW;
                        cnt_nxt   = SHOW_LOAD;
                        anode_nxt = 8'd1 << sel;
                        blank_nxt = 1'b0;
                    end else begin
                        if (hit_here[3]) sel_nxt = hit_here[2:0];
                        cnt_nxt = BLANK_LOAD;
                    end
                end
                S_SHOW: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CW'(1);
                    end else begin
                        state_nxt = S_BLANK;
                        cnt_nxt   = BLANK_LOAD;
                        anode_nxt = '0;
                        blank_nxt = 1'b1;
                        if (hit_next[3]) begin
                            sel_nxt        = hit_next[2:0];
                            frame_done_nxt = (hit_next[2:0] <= sel);
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sel        <= '0;
            anode      <= '0;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sel        <= sel_nxt;
            anode      <= anode_nxt;
            blank      <= blank_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller: phase-based reference model
// compared every cycle, plus directed scenario checks with literal expectations.
module tb_display_scan_controller;

    localparam int ND = 4;
    localparam int PS = 4;
    localparam int BK = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] digit_mask = 8'h0F;
    logic [2:0] sel;
    logic [7:0] anode;
    logic       blank;
    logic       frame_done;

    always #5 clock = ~clock;

    display_scan_controller #(
        .PRESCALE(PS),
        .BLANK(BK),
        .NUM_DIGITS(ND)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .digit_mask(digit_mask),
        .sel(sel),
        .anode(anode),
        .blank(blank),
        .frame_done(frame_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: scanning is a period of BK dark cycles then PS lit
    // cycles; m_ph is the position within that period.
    bit m_on  = 1'b0;
    int m_ph  = 0;
    int m_sel = 0;
    bit m_fd  = 1'b0;
    bit chk_en = 1'b0;

    function automatic int search(input logic [7:0] m, input int start);
        for (int k = 0; k < ND; k++) begin
            int j;
            j = (start + k) % ND;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clock) begin
        logic [7:0] m;
        int nx;
        m = digit_mask & 8'h0F;
        m_fd = 1'b0;
        if (reset || !enable) begin
            m_on = 1'b0; m_ph = 0; m_sel = 0;
        end else if (!m_on) begin
            m_on = 1'b1; m_ph = 0;
            nx = search(m, 0);
            m_sel = (nx < 0) ? 0 : nx;
        end else if (m_ph == BK - 1) begin
            if (m[m_sel]) m_ph = BK;
            else begin
                nx = search(m, m_sel);
                if (nx >= 0) m_sel = nx;
                m_ph = 0;
            end
        end else if (m_ph == BK + PS - 1) begin
            nx = search(m, m_sel + 1);
            if (nx >= 0) begin
                m_fd = (nx <= m_sel);
                m_sel = nx;
            end
            m_ph = 0;
        end else begin
            m_ph++;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            bit exp_blank;
            exp_blank = !(m_on && m_ph >= BK);
            chk("model_sel", sel, m_sel);
            chk("model_anode", anode, exp_blank ? 0 : (1 << m_sel));
            chk("model_blank", blank, exp_blank);
            chk("model_frame_done", frame_done, m_fd);
        end
    end

    int         lit_cyc[ND];
    int         fd_cnt;
    int         first_lit;
    int         unblank_cnt;
    logic [7:0] lit_seq[$];

    task automatic observe(input int n);
        logic [7:0] prev_an;
        for (int k = 0; k < ND; k++) lit_cyc[k] = 0;
        fd_cnt = 0; first_lit = -1; unblank_cnt = 0;
        lit_seq.delete();
        prev_an = anode;
        for (int c = 1; c <= n; c++) begin
            @(negedge clock);
            if (anode != 0) begin
                if (first_lit < 0) first_lit = c;
                lit_cyc[sel]++;
                if (prev_an == 0) lit_seq.push_back(anode);
            end
            if (!blank) unblank_cnt++;
            fd_cnt += int'(frame_done);
            prev_an = anode;
        end
    endtask

    task automatic wait_lit(input int digit);
        int c;
        c = 0;
        while (anode != (8'd1 << digit) && c < 100) begin
            @(negedge clock);
            c++;
        end
        chk("wait_lit_in_budget", int'(c < 100), 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_anode"}, anode, 0);
        chk({tag, "_blank"}, blank, 1);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    initial begin
        @(negedge clock);
        chk_en = 1'b1;
        repeat (2) @(negedge clock);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clock);

        // Full mask scan
        enable = 1'b1;
        observe(24);
        chk("s1_first_lit", first_lit, BK + 1);
        chk("s1_lit_count", lit_seq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("s1_lit_order", (lit_seq.size() > i) ? int'(lit_seq[i]) : -1, 1 << i);
            chk("s1_lit_len", lit_cyc[i], PS);
        end
        chk("s1_no_early_fd", fd_cnt, 0);
        observe(48);
        chk("s1_fd_per_48", fd_cnt, 2);

        // Alternate digits; upper mask bits must be ignored
        digit_mask = 8'hFA;
        observe(36);
        observe(24);
        chk("s2_d0", lit_cyc[0], 0);
        chk("s2_d1", lit_cyc[1], 8);
        chk("s2_d2", lit_cyc[2], 0);
        chk("s2_d3", lit_cyc[3], 8);
        chk("s2_fd", fd_cnt, 2);

        // Single digit
        digit_mask = 8'h04;
        observe(24);
        observe(24);
        chk("s3_d2", lit_cyc[2], 16);
        chk("s3_fd", fd_cnt, 4);

        // Empty mask stays dark, then recovers
        digit_mask = 8'h00;
        observe(12);
        observe(30);
        chk("s4_dark_lit", lit_cyc[0] + lit_cyc[1] + lit_cyc[2] + lit_cyc[3], 0);
        chk("s4_dark_unblank", unblank_cnt, 0);
        digit_mask = 8'h01;
        observe(12);
        chk("s4_lit_soon", int'(first_lit >= 1 && first_lit <= 2 * BK), 1);
        chk("s4_lit_digit", (lit_seq.size() > 0) ? int'(lit_seq[0]) : -1, 1);

        // Drop enable mid-SHOW, then restart on lowest set digit
        digit_mask = 8'h0E;
        wait_lit(1);
        enable = 1'b0;
        @(negedge clock);
        chk("s5_off_anode", anode, 0);
        chk("s5_off_blank", blank, 1);
        chk("s5_off_sel", sel, 0);
        enable = 1'b1;
        observe(6);
        chk("s5_first_lit", first_lit, BK + 1);
        chk("s5_lit_digit", (lit_seq.size() > 0) ? int'(lit_seq[0]) : -1, 2);

        // Reset mid-SHOW with enable high, then mask change during digit 0
        digit_mask = 8'h0F;
        wait_lit(2);
        reset = 1'b1;
        @(negedge clock);
        chk_reset_vals("s6_rst");
        reset = 1'b0;
        observe(3);
        chk("s6_first_lit", first_lit, BK + 1);
        chk("s6_lit_digit", anode, 1);
        digit_mask = 8'h0E;
        observe(30);
        chk("s6_d0_completes", lit_cyc[0], PS - 1);
        chk("s6_d1", lit_cyc[1], 8);

        // Randomized traffic against the model
        enable = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            int r;
            @(negedge clock);
            r = int'($urandom_range(0, 199));
            reset = 1'b0;
            if (r < 4) enable = ~enable;
            else if (r < 10) digit_mask = 8'($urandom);
            else if (r == 10) reset = 1'b1;
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
